// File: rtl/vmop_issue_if.sv
// vmop_issue_if: bundles the request handshake, the VRF read port and the
// mask-logic output beat stream of vmop_issue.
//   slave  : the issue unit (takes requests and read data, drives reads and beats)
//   master : the environment (drives requests and VRF data, observes the rest)
// Request side : req_valid/req_ready, req_vs1/req_vs2/req_vd, req_opSel, req_nbeats
// VRF side     : rd_en, rd_addr0/rd_addr1 ({reg, beat}), rd_data0/rd_data1 (1-cycle latency)
// Output side  : out_valid, out_m0/out_m1, out_opSel, out_addr ({vd, beat}), done, busy
interface vmop_issue_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 3,
    parameter int REG_WIDTH   = 5,
    parameter int BEAT_WIDTH  = 3
);
    logic                              req_valid;
    logic                              req_ready;
    logic [REG_WIDTH-1:0]              req_vs1;
    logic [REG_WIDTH-1:0]              req_vs2;
    logic [REG_WIDTH-1:0]              req_vd;
    logic [OPSEL_WIDTH-1:0]            req_opSel;
    logic [BEAT_WIDTH-1:0]             req_nbeats;

    logic                              rd_en;
    logic [REG_WIDTH+BEAT_WIDTH-1:0]   rd_addr0;
    logic [REG_WIDTH+BEAT_WIDTH-1:0]   rd_addr1;
    logic [DATA_WIDTH-1:0]             rd_data0;
    logic [DATA_WIDTH-1:0]             rd_data1;

    logic [DATA_WIDTH-1:0]             out_m0;
    logic [DATA_WIDTH-1:0]             out_m1;
    logic [OPSEL_WIDTH-1:0]            out_opSel;
    logic [ADDR_WIDTH-1:0]             out_addr;
    logic                              out_valid;
    logic                              done;
    logic                              busy;

    modport slave (
        input  req_valid, req_vs1, req_vs2, req_vd, req_opSel, req_nbeats,
        input  rd_data0, rd_data1,
        output req_ready, rd_en, rd_addr0, rd_addr1,
        output out_m0, out_m1, out_opSel, out_addr, out_valid, done, busy
    );

    modport master (
        output req_valid, req_vs1, req_vs2, req_vd, req_opSel, req_nbeats,
        output rd_data0, rd_data1,
        input  req_ready, rd_en, rd_addr0, rd_addr1,
        input  out_m0, out_m1, out_opSel, out_addr, out_valid, done, busy
    );
endinterface

// File: rtl/vmop_issue.sv
// vmop_issue: accepts one vector mask-logic instruction, reads its source
// registers beat by beat from the VRF and streams the operand pairs, tagged
// with destination address and op select, to the mask-logic unit.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous, active-high reset
//   io  - vmop_issue_if.slave: request handshake, VRF read port, output beats
module vmop_issue #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 3,
    parameter int REG_WIDTH   = 5,
    parameter int BEAT_WIDTH  = 3
) (
    input  logic         clk,
    input  logic         rst,
    vmop_issue_if.slave  io
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                   state_q, state_d;
    logic [BEAT_WIDTH-1:0]    beat_q, beat_d;
    logic [REG_WIDTH-1:0]     vs1_q, vs1_d;
    logic [REG_WIDTH-1:0]     vs2_q, vs2_d;
    logic [REG_WIDTH-1:0]     vd_q, vd_d;
    logic [OPSEL_WIDTH-1:0]   op_q, op_d;
    logic [BEAT_WIDTH-1:0]    nbeats_q, nbeats_d;

    logic                     issue;
    logic                     is_last;
    logic [BEAT_WIDTH-1:0]    last_beat;

    // Tag stage 1: aligned with rd_data arriving from the VRF.
    logic                     s1_valid_q;
    logic [REG_WIDTH-1:0]     s1_vd_q;
    logic [BEAT_WIDTH-1:0]    s1_beat_q;
    logic [OPSEL_WIDTH-1:0]   s1_op_q;
    logic                     s1_last_q;

    // Tag stage 2: registered outputs.
    logic                     out_valid_q;
    logic [DATA_WIDTH-1:0]    out_m0_q;
    logic [DATA_WIDTH-1:0]    out_m1_q;
    logic [OPSEL_WIDTH-1:0]   out_op_q;
    logic [ADDR_WIDTH-1:0]    out_addr_q;
    logic                     done_q;

    // nbeats==0 encodes 2^BEAT_WIDTH; modular subtraction yields the all-ones
    // last index in that case, so one compare covers every count.
    assign last_beat = nbeats_q - BEAT_WIDTH'(1);
    assign is_last   = (beat_q == last_beat);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        vs1_d    = vs1_q;
        vs2_d    = vs2_q;
        vd_d     = vd_q;
        op_d     = op_q;
        nbeats_d = nbeats_q;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.req_valid) begin
                    vs1_d    = io.req_vs1;
                    vs2_d    = io.req_vs2;
                    vd_d     = io.req_vd;
                    op_d     = io.req_opSel;
                    nbeats_d = io.req_nbeats;
                    beat_d   = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                issue  = 1'b1;
                beat_d = beat_q + BEAT_WIDTH'(1);
                if (is_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            vd_q        <= '0;
            op_q        <= '0;
            nbeats_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_vd_q     <= '0;
            s1_beat_q   <= '0;
            s1_op_q     <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_m0_q    <= '0;
            out_m1_q    <= '0;
            out_op_q    <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            vd_q        <= vd_d;
            op_q        <= op_d;
            nbeats_q    <= nbeats_d;

            s1_valid_q  <= issue;
            s1_vd_q     <= vd_q;
            s1_beat_q   <= beat_q;
            s1_op_q     <= op_q;
            s1_last_q   <= issue && is_last;

            // Payload fields are zeroed rather than held so idle outputs read 0.
            out_valid_q <= s1_valid_q;
            out_m0_q    <= s1_valid_q ? io.rd_data0 : '0;
            out_m1_q    <= s1_valid_q ? io.rd_data1 : '0;
            out_op_q    <= s1_valid_q ? s1_op_q : '0;
            out_addr_q  <= s1_valid_q ? ADDR_WIDTH'({s1_vd_q, s1_beat_q}) : '0;
            done_q      <= s1_valid_q && s1_last_q;
        end
    end

    // rst gates every output so the port is quiet for the whole reset cycle,
    // not only after the first reset edge.
    assign io.req_ready = (state_q == IDLE) && !rst;
    assign io.rd_en     = issue && !rst;
    assign io.rd_addr0  = io.rd_en ? {vs1_q, beat_q} : '0;
    assign io.rd_addr1  = io.rd_en ? {vs2_q, beat_q} : '0;
    assign io.out_valid = out_valid_q && !rst;
    assign io.out_m0    = rst ? '0 : out_m0_q;
    assign io.out_m1    = rst ? '0 : out_m1_q;
    assign io.out_opSel = rst ? '0 : out_op_q;
    assign io.out_addr  = rst ? '0 : out_addr_q;
    assign io.done      = done_q && !rst;
    assign io.busy      = ((state_q == ISSUE) || s1_valid_q || out_valid_q) && !rst;

endmodule
